// File: rtl/mealey_win_types.sv
// Shared record type, constants and helpers for the Mealy window statistics block.
// Field avg exists only when MEALEY_WIN_AVG_EN is defined.
package mealey_win_types;

  typedef struct packed {
    logic signed [8:0] delta;
    logic signed [8:0] max;
    logic signed [8:0] min;
`ifdef MEALEY_WIN_AVG_EN
    logic signed [8:0] avg;
`endif
  } win_rec_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == DROP_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mealey_rec_fifo.sv
// Synchronous record FIFO; a push while full is accepted when a pop happens in the same cycle.
// The head record is held in its own register so the outputs never see the write port.
module mealey_rec_fifo
  import mealey_win_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     system1000,
  input  logic     system1000_rstn,
  input  logic     push,
  input  win_rec_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output logic     valid,
  output win_rec_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mealey_rec_fifo: DEPTH must be a power of two and at least 2");
  end

  win_rec_t         mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  win_rec_t         head_r;

  logic             pop_s;
  logic             push_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] remain_s;
  logic [PTR_W-1:0] rd_ptr_s;
  win_rec_t         head_s;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign valid = valid_r;
  assign head  = head_r;

  // Accept/retire decisions and the next head value.
  always_comb begin
    pop_s    = pop && !empty;
    push_s   = push && (!full || pop_s);
    remain_s = count_r - CNT_W'(pop_s);
    count_s  = remain_s + CNT_W'(push_s);
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    // With nothing left after the pop, a pushed record becomes the head directly.
    if (remain_s == {CNT_W{1'b0}}) begin
      if (push_s) begin
        head_s = push_data;
      end else begin
        head_s = head_r;
      end
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      valid_r  <= (count_s != {CNT_W{1'b0}});
      head_r   <= head_s;
    end
  end

endmodule

// File: rtl/mealey_window_stats.sv
// Windowed delta/max/min statistics over the Mealy accumulator's running sum.
// Define MEALEY_WIN_AVG_EN to add rec_avg_o (delta >>> log2(WINDOW)).
module mealey_window_stats
  import mealey_win_types::*;
#(
  parameter int WINDOW = 8,
  parameter int DEPTH  = 2
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic signed [8:0] sum_i,
  input  logic              clear_i,
  output logic              rec_valid_o,
  input  logic              rec_ready_i,
  output logic signed [8:0] rec_delta_o,
  output logic signed [8:0] rec_max_o,
  output logic signed [8:0] rec_min_o,
`ifdef MEALEY_WIN_AVG_EN
  output logic signed [8:0] rec_avg_o,
`endif
  output logic [7:0]        drop_cnt_o
);

  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  if (WINDOW < 2 || WINDOW > 256) begin : g_bad_window
    $error("mealey_window_stats: WINDOW must be in 2..256");
  end
`ifdef MEALEY_WIN_AVG_EN
  if ((1 << CNT_W) != WINDOW) begin : g_bad_avg_window
    $error("mealey_window_stats: WINDOW must be a power of two when averaging");
  end
`endif

  logic [CNT_W-1:0]  cnt_r;
  logic signed [8:0] base_r;
  logic signed [8:0] cur_max_r;
  logic signed [8:0] cur_min_r;
  logic [7:0]        drop_cnt_r;

  logic              win_end_s;
  logic signed [8:0] win_max_s;
  logic signed [8:0] win_min_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  win_rec_t          rec_s;
  win_rec_t          head_s;

  // Running extremes including the current sample, and the candidate record.
  always_comb begin
    win_end_s = (cnt_r == LAST);
    if (cnt_r == {CNT_W{1'b0}}) begin
      win_max_s = sum_i;
      win_min_s = sum_i;
    end else begin
      win_max_s = (sum_i > cur_max_r) ? sum_i : cur_max_r;
      win_min_s = (sum_i < cur_min_r) ? sum_i : cur_min_r;
    end
    rec_s       = '0;
    rec_s.delta = sum_i - base_r;
    rec_s.max   = win_max_s;
    rec_s.min   = win_min_s;
`ifdef MEALEY_WIN_AVG_EN
    rec_s.avg   = rec_s.delta >>> CNT_W;
`endif
    pop_s  = rec_ready_i && !empty_s;
    push_s = win_end_s && !clear_i;
    drop_s = push_s && full_s && !pop_s;
  end

  // Window position, base and extreme tracking; clear restarts the window from this sample.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      cnt_r     <= {CNT_W{1'b0}};
      base_r    <= 9'sd0;
      cur_max_r <= 9'sd0;
      cur_min_r <= 9'sd0;
    end else if (clear_i) begin
      cnt_r     <= {CNT_W{1'b0}};
      base_r    <= sum_i;
      cur_max_r <= cur_max_r;
      cur_min_r <= cur_min_r;
    end else begin
      cur_max_r <= win_max_s;
      cur_min_r <= win_min_s;
      if (win_end_s) begin
        cnt_r  <= {CNT_W{1'b0}};
        base_r <= sum_i;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        base_r <= base_r;
      end
    end
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc8(drop_cnt_r);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  mealey_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .push            (push_s),
    .push_data       (rec_s),
    .pop             (pop_s),
    .full            (full_s),
    .empty           (empty_s),
    .valid           (rec_valid_o),
    .head            (head_s)
  );

  assign rec_delta_o = head_s.delta;
  assign rec_max_o   = head_s.max;
  assign rec_min_o   = head_s.min;
`ifdef MEALEY_WIN_AVG_EN
  assign rec_avg_o   = head_s.avg;
`endif
  assign drop_cnt_o  = drop_cnt_r;

endmodule

// File: tb/tb_mealey_window_stats.sv
// Self-checking bench for mealey_window_stats (WINDOW=4, DEPTH=2): directed scenarios plus
// randomized traffic against a sample-list/queue reference model.
`timescale 1ns/1ps
module tb_mealey_window_stats;

  localparam int WINDOW = 4;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [8:0] sum;
  logic              clr;
  logic              rdy;
  logic              rec_valid_o;
  logic signed [8:0] rec_delta_o;
  logic signed [8:0] rec_max_o;
  logic signed [8:0] rec_min_o;
  logic signed [8:0] rec_avg_o;
  logic [7:0]        drop_cnt_o;

  always #5 clk = ~clk;

  mealey_window_stats #(
    .WINDOW (WINDOW),
    .DEPTH  (DEPTH)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .sum_i           (sum),
    .clear_i         (clr),
    .rec_valid_o     (rec_valid_o),
    .rec_ready_i     (rdy),
    .rec_delta_o     (rec_delta_o),
    .rec_max_o       (rec_max_o),
    .rec_min_o       (rec_min_o),
`ifdef MEALEY_WIN_AVG_EN
    .rec_avg_o       (rec_avg_o),
`endif
    .drop_cnt_o      (drop_cnt_o)
  );

`ifndef MEALEY_WIN_AVG_EN
  assign rec_avg_o = 9'sd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int d;
    int mx;
    int mn;
    int av;
  } mrec_t;

  mrec_t m_q[$];
  int    m_win[$];
  int    m_base = 0;
  int    m_drop = 0;

  function automatic int wrap9(input int v);
    int w;
    w = v & 511;
    if (w > 255) w = w - 512;
    return w;
  endfunction

  function automatic int floordiv(input int v, input int d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Reference: windows are lists of samples; records live in a bounded queue.
  function automatic void model_update();
    bit    pop;
    bit    take;
    mrec_t r;
    if (!rstn) begin
      m_q.delete();
      m_win.delete();
      m_base = 0;
      m_drop = 0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    if (clr) begin
      m_win.delete();
      m_base = int'(sum);
      if (pop) void'(m_q.pop_front());
      return;
    end
    m_win.push_back(int'(sum));
    if (m_win.size() == WINDOW) begin
      r.d  = wrap9(int'(sum) - m_base);
      r.mx = m_win[0];
      r.mn = m_win[0];
      foreach (m_win[k]) begin
        if (m_win[k] > r.mx) r.mx = m_win[k];
        if (m_win[k] < r.mn) r.mn = m_win[k];
      end
      r.av   = floordiv(r.d, WINDOW);
      m_base = int'(sum);
      m_win.delete();
      take = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (take) m_q.push_back(r);
      else if (m_drop < 255) m_drop++;
    end else if (pop) begin
      void'(m_q.pop_front());
    end
  endfunction

  task automatic step(input logic signed [8:0] s, input logic c, input logic r);
    sum = s;
    clr = c;
    rdy = r;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step(9'sd17, 1'b0, 1'b0);
    step(9'sd5, 1'b0, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", rec_valid_o); end
    n_cmp++; if (rec_delta_o !== 9'sd0) begin n_bad++; $display("FAIL reset_delta: got %0d want 0", rec_delta_o); end
    n_cmp++; if (rec_max_o !== 9'sd0) begin n_bad++; $display("FAIL reset_max: got %0d want 0", rec_max_o); end
    n_cmp++; if (rec_min_o !== 9'sd0) begin n_bad++; $display("FAIL reset_min: got %0d want 0", rec_min_o); end
    n_cmp++; if (drop_cnt_o !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    step(9'sd0, 1'b0, 1'b0);
    step(9'sd3, 1'b0, 1'b0);
    step(9'sd6, 1'b0, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_early: got %0b want 0", rec_valid_o); end
    step(9'sd9, 1'b0, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", rec_valid_o); end
    n_cmp++; if (rec_delta_o !== 9'sd9) begin n_bad++; $display("FAIL basic_delta: got %0d want 9", rec_delta_o); end
    n_cmp++; if (rec_max_o !== 9'sd9) begin n_bad++; $display("FAIL basic_max: got %0d want 9", rec_max_o); end
    n_cmp++; if (rec_min_o !== 9'sd0) begin n_bad++; $display("FAIL basic_min: got %0d want 0", rec_min_o); end
  endtask

  task automatic test_wrap();
    step(9'sd100, 1'b0, 1'b1);
    step(9'sd100, 1'b0, 1'b0);
    step(9'sd100, 1'b0, 1'b0);
    step(9'sd250, 1'b0, 1'b0);
    n_cmp++; if (rec_delta_o !== 9'sd241) begin n_bad++; $display("FAIL wrap_pre_delta: got %0d want 241", rec_delta_o); end
    step(9'sd200, 1'b0, 1'b1);
    step(-9'sd100, 1'b0, 1'b0);
    step(-9'sd256, 1'b0, 1'b0);
    step(-9'sd250, 1'b0, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b1) begin n_bad++; $display("FAIL wrap_valid: got %0b want 1", rec_valid_o); end
    n_cmp++; if (rec_delta_o !== 9'sd12) begin n_bad++; $display("FAIL wrap_delta: got %0d want 12", rec_delta_o); end
    n_cmp++; if (rec_max_o !== 9'sd200) begin n_bad++; $display("FAIL wrap_max: got %0d want 200", rec_max_o); end
    n_cmp++; if (rec_min_o !== -9'sd256) begin n_bad++; $display("FAIL wrap_min: got %0d want -256", rec_min_o); end
  endtask

  task automatic test_backpressure();
    // Window A (delta 4-(-250)=254), then B (delta 4), then C is dropped.
    step(9'sd1, 1'b0, 1'b1);
    step(9'sd2, 1'b0, 1'b0);
    step(9'sd3, 1'b0, 1'b0);
    step(9'sd4, 1'b0, 1'b0);
    for (int i = 5; i <= 8; i++) step(9'(i), 1'b0, 1'b0);
    n_cmp++; if (rec_delta_o !== 9'sd254) begin n_bad++; $display("FAIL bp_hold_delta: got %0d want 254", rec_delta_o); end
    for (int i = 9; i <= 12; i++) step(9'(i), 1'b0, 1'b0);
    n_cmp++; if (drop_cnt_o !== 8'd1) begin n_bad++; $display("FAIL bp_drop: got %0d want 1", drop_cnt_o); end
    n_cmp++; if (rec_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %0b want 1", rec_valid_o); end
    n_cmp++; if (rec_delta_o !== 9'sd254) begin n_bad++; $display("FAIL bp_stable_delta: got %0d want 254", rec_delta_o); end
    n_cmp++; if (rec_max_o !== 9'sd4) begin n_bad++; $display("FAIL bp_stable_max: got %0d want 4", rec_max_o); end
    n_cmp++; if (rec_min_o !== 9'sd1) begin n_bad++; $display("FAIL bp_stable_min: got %0d want 1", rec_min_o); end
    step(9'sd13, 1'b0, 1'b0);
    step(9'sd14, 1'b0, 1'b0);
    step(9'sd15, 1'b0, 1'b0);
    step(9'sd16, 1'b0, 1'b1);
    n_cmp++; if (drop_cnt_o !== 8'd1) begin n_bad++; $display("FAIL bp_fullpop_drop: got %0d want 1", drop_cnt_o); end
    n_cmp++; if (rec_max_o !== 9'sd8) begin n_bad++; $display("FAIL bp_next_max: got %0d want 8", rec_max_o); end
    n_cmp++; if (rec_delta_o !== 9'sd4) begin n_bad++; $display("FAIL bp_next_delta: got %0d want 4", rec_delta_o); end
    step(9'sd20, 1'b0, 1'b1);
    n_cmp++; if (rec_max_o !== 9'sd16 || rec_min_o !== 9'sd13) begin
      n_bad++; $display("FAIL bp_accepted: got max %0d min %0d want 16 13", rec_max_o, rec_min_o);
    end
  endtask

  task automatic test_clear();
    step(9'sd21, 1'b0, 1'b1);
    step(9'sd40, 1'b1, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL clear_norec: got %0b want 0", rec_valid_o); end
    for (int i = 41; i <= 44; i++) step(9'(i), 1'b0, 1'b0);
    n_cmp++; if (rec_valid_o !== 1'b1) begin n_bad++; $display("FAIL clear_valid: got %0b want 1", rec_valid_o); end
    n_cmp++; if (rec_delta_o !== 9'sd4) begin n_bad++; $display("FAIL clear_delta: got %0d want 4", rec_delta_o); end
    n_cmp++; if (rec_max_o !== 9'sd44) begin n_bad++; $display("FAIL clear_max: got %0d want 44", rec_max_o); end
    n_cmp++; if (rec_min_o !== 9'sd41) begin n_bad++; $display("FAIL clear_min: got %0d want 41", rec_min_o); end
    n_cmp++; if (drop_cnt_o !== 8'd1) begin n_bad++; $display("FAIL clear_drop: got %0d want 1", drop_cnt_o); end
  endtask

  task automatic test_reset_mid();
    step(9'sd50, 1'b0, 1'b0);
    step(9'sd51, 1'b0, 1'b0);
    rstn = 1'b0;
    step(9'sd52, 1'b0, 1'b0);
    rstn = 1'b1;
    n_cmp++; if (rec_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0b want 0", rec_valid_o); end
    n_cmp++; if (drop_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt_o); end
    for (int i = 5; i <= 8; i++) step(9'(i), 1'b0, 1'b0);
    n_cmp++; if (rec_delta_o !== 9'sd8) begin n_bad++; $display("FAIL rmid_delta: got %0d want 8", rec_delta_o); end
    n_cmp++; if (rec_min_o !== 9'sd5) begin n_bad++; $display("FAIL rmid_min: got %0d want 5", rec_min_o); end
  endtask

`ifdef MEALEY_WIN_AVG_EN
  task automatic test_avg();
    rstn = 1'b0;
    step(9'sd0, 1'b0, 1'b0);
    rstn = 1'b1;
    step(9'sd0, 1'b0, 1'b0);
    step(9'sd8, 1'b0, 1'b0);
    step(9'sd16, 1'b0, 1'b0);
    step(9'sd32, 1'b0, 1'b0);
    n_cmp++; if (rec_avg_o !== 9'sd8) begin n_bad++; $display("FAIL avg_pos: got %0d want 8", rec_avg_o); end
    rstn = 1'b0;
    step(9'sd0, 1'b0, 1'b0);
    rstn = 1'b1;
    step(-9'sd4, 1'b0, 1'b0);
    step(-9'sd8, 1'b0, 1'b0);
    step(-9'sd12, 1'b0, 1'b0);
    step(-9'sd13, 1'b0, 1'b0);
    n_cmp++; if (rec_delta_o !== -9'sd13) begin n_bad++; $display("FAIL avg_neg_delta: got %0d want -13", rec_delta_o); end
    n_cmp++; if (rec_avg_o !== -9'sd4) begin n_bad++; $display("FAIL avg_neg: got %0d want -4", rec_avg_o); end
  endtask
`endif

  task automatic test_random();
    logic signed [8:0] rs;
    logic              rr;
    rstn = 1'b0;
    step(9'sd0, 1'b0, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rs = 9'($urandom_range(0, 511));
      rr = (i < 700) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      rstn = ($urandom_range(0, 199) != 0);
      step(rs, $urandom_range(0, 11) == 0, rr);
      rstn = 1'b1;
      n_cmp++;
      if (rec_valid_o !== (m_q.size() > 0)) begin
        n_bad++; $display("FAIL rand_valid @%0d: got %0b want %0b", i, rec_valid_o, m_q.size() > 0);
      end else if (m_q.size() > 0) begin
        n_cmp++;
        if (rec_delta_o !== m_q[0].d || rec_max_o !== m_q[0].mx || rec_min_o !== m_q[0].mn) begin
          n_bad++;
          $display("FAIL rand_rec @%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                   rec_delta_o, rec_max_o, rec_min_o, m_q[0].d, m_q[0].mx, m_q[0].mn);
        end
`ifdef MEALEY_WIN_AVG_EN
        n_cmp++;
        if (rec_avg_o !== m_q[0].av) begin
          n_bad++; $display("FAIL rand_avg @%0d: got %0d want %0d", i, rec_avg_o, m_q[0].av);
        end
`endif
      end
      n_cmp++;
      if (drop_cnt_o !== 8'(m_drop)) begin
        n_bad++; $display("FAIL rand_drop @%0d: got %0d want %0d", i, drop_cnt_o, m_drop);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    sum  = 9'sd0;
    clr  = 1'b0;
    rdy  = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear();
    test_reset_mid();
`ifdef MEALEY_WIN_AVG_EN
    test_avg();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mealey_window_stats.md
Name: mealey_window_stats

Overview:
- Downstream consumer of the Mealy running-sum accumulator. Samples the accumulator's 9-bit signed output every clock and partitions it into fixed windows of WINDOW samples.
- Per window, emits one record: modular delta of the running sum since the previous window end, plus the maximum and minimum sum values seen in the window.
- Records leave through a valid/ready interface via a small FIFO. Records are dropped, and counted, when the FIFO is full.

Parameters:
- WINDOW, 8: samples per window; legal range 2..256.
- DEPTH, 2: record FIFO entries; power of two, ≥2.

Ports:
- system1000  in  1  clock; all logic on its rising edge.
- system1000_rstn  in  1  reset, synchronous, active-low.
- sum_i  in  9 signed  running sum from the accumulator; valid every cycle.
- clear_i  in  1  synchronous window restart.
- rec_valid_o  out  1  FIFO head valid.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_delta_o  out  9 signed  head record: sum delta.
- rec_max_o  out  9 signed  head record: window maximum.
- rec_min_o  out  9 signed  head record: window minimum.
- drop_cnt_o  out  8  saturating count of dropped records.

Behaviour:
- Reset (system1000_rstn low at a clock edge):
  - cnt=0, base=0 (equals the accumulator reset value), max/min tracking cleared.
  - FIFO emptied; rec_valid_o=0; rec_delta_o/rec_max_o/rec_min_o=0; drop_cnt_o=0.
  - Reset mid-window discards the partial window and all queued records.
- Window counter cnt runs 0..WINDOW-1; increments each non-reset, non-clear cycle; wraps to 0 after WINDOW-1.
- Max/min tracking:
  - At cnt==0: cur_max=cur_min=sum_i.
  - Otherwise: cur_max=max(cur_max,sum_i), cur_min=min(cur_min,sum_i).
  - All comparisons are signed.
- Window end (cnt==WINDOW-1), in the same cycle:
  - Record = {delta = sum_i - base, truncated to 9 bits (mod 512, two's-complement wrap); max/min including this sample}.
  - base <= sum_i. Consecutive windows share the boundary sample, so there is no gap in coverage.
- Push rule: the record is written to the FIFO if not full, or if full and a pop happens in the same cycle (rec_valid_o && rec_ready_i). Otherwise the record is dropped and drop_cnt_o increments, saturating at 255.
- Latency: record visible on rec_* with rec_valid_o=1 on the cycle after the window-end sample when the FIFO was empty.
- Handshake:
  - Pop when rec_valid_o && rec_ready_i.
  - rec_* hold stable while rec_valid_o && !rec_ready_i.
  - rec_* are don't-care when rec_valid_o=0; the implementation holds the last value.
- clear_i=1 (priority below reset, above window end):
  - cnt<=0, base<=sum_i; the partial window is discarded with no record and no drop count.
  - FIFO and drop_cnt_o untouched; a pop in the same cycle still proceeds.
- Simultaneous push and pop on an empty FIFO: the record is written and valid next cycle; the pop is a no-op, since rec_valid_o was 0.
- Outputs are registered from FIFO storage; there is no combinational path from sum_i to rec_*.

Optional Feature:
- MEALEY_WIN_AVG_EN defined:
  - Adds output rec_avg_o (9 signed) = rec_delta_o >>> log2(WINDOW), arithmetic shift, stored per FIFO entry.
  - WINDOW must be a power of two; elaboration error otherwise.
- Undefined: port and storage absent.

Decomposition:
- Package mealey_win_types:
  - win_rec_t packed struct {delta, max, min [, avg]}, each logic signed [8:0].
  - Constant DROP_MAX=8'd255.
- Sub-module mealey_rec_fifo:
  - Synchronous FIFO of win_rec_t, DEPTH entries.
  - push/pop/full/empty interface, same clock and reset.
  - Full-with-pop accepts the push.

Test Plan (all with WINDOW=4, DEPTH=2 unless noted):
- Basic window: reset, then sum_i=0,3,6,9 -> next cycle rec_valid_o=1, delta=9, max=9, min=0.
- Wrap: base=250 from the prior window end, window sum_i=200,-100,-256,-250 -> delta=12 (−500 mod 512), max=200, min=-256.
- Backpressure/drop: rec_ready_i=0 for 3 windows -> 2 records held stable, third dropped, drop_cnt_o=1. Then rec_ready_i=1 for one cycle coinciding with a window end -> push accepted, drop_cnt_o stays 1.
- Clear: clear_i pulsed at cnt=2 with sum_i=40, then 41,42,43,44 -> one record, delta=4, max=44, min=41; drop_cnt_o unchanged.
- Reset mid-operation: FIFO holding 1 record, cnt=2; assert system1000_rstn=0 one cycle -> rec_valid_o=0, drop_cnt_o=0. Next window delta is computed against base 0.
- MEALEY_WIN_AVG_EN: sum_i=0,8,16,32 -> rec_avg_o=8. sum_i=-4,-8,-12,-13 -> delta=-13, rec_avg_o=-4.
